// File: rtl/pe_result_collector.sv
// pe_result_collector: buffers a PE column's non-backpressured result bus in a FIFO,
// re-presents it as ready/valid, and flags overflow, group-id and dataflow errors.
module pe_result_collector #(
  parameter int C_W    = 20,
  parameter int ID_W   = 3,
  parameter int DEPTH  = 8,
  parameter int TCNT_W = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic [C_W-1:0]             in_c,
  input  logic [ID_W-1:0]            in_id,
  input  logic                       in_last,
  input  logic                       in_propagate,
  input  logic                       in_bad_dataflow,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [C_W-1:0]             out_c,
  output logic [ID_W-1:0]            out_id,
  output logic                       out_last,
  output logic                       out_propagate,
  output logic [$clog2(DEPTH):0]     level,
  output logic [TCNT_W-1:0]          tiles_done,
  output logic                       err_overflow,
  output logic                       err_id,
  output logic                       err_dataflow,
  input  logic                       clear_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = C_W + ID_W + 2;
  typedef enum logic {IDLE, IN_GROUP} state_t;
  state_t state, state_next;
  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [ID_W-1:0] grp_id, grp_id_next;
  logic full, pop, push, ov_ev, id_ev, df_ev;
  assign full = level == (AW+1)'(DEPTH);
  assign out_valid = level != '0;
  assign pop = out_valid && out_ready;
  // a full FIFO still accepts when the head leaves in the same cycle
  assign push = in_valid && (!full || pop);
  assign {out_c, out_id, out_last, out_propagate} = mem[rp];
  assign ov_ev = in_valid && !push;
  assign df_ev = in_valid && in_bad_dataflow;
  always_ff @(posedge clk)
    if (push) mem[wp] <= {in_c, in_id, in_last, in_propagate};
  always_comb begin
    state_next = state;
    grp_id_next = grp_id;
    id_ev = 1'b0;
    if (in_valid) begin
      state_next = in_last ? IDLE : IN_GROUP;
      grp_id_next = (state == IDLE) ? in_id : grp_id;
      id_ev = (state == IN_GROUP) && (in_id != grp_id);
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      grp_id <= '0;
      wp <= '0;
      rp <= '0;
      level <= '0;
      tiles_done <= '0;
      err_overflow <= 1'b0;
      err_id <= 1'b0;
      err_dataflow <= 1'b0;
    end else begin
      state <= state_next;
      grp_id <= grp_id_next;
      wp <= push ? wp + AW'(1) : wp;
      rp <= pop ? rp + AW'(1) : rp;
      level <= level + (AW+1)'(push) - (AW+1)'(pop);
      tiles_done <= tiles_done + TCNT_W'(pop && out_last);
      err_overflow <= (err_overflow && !clear_err) || ov_ev;
      err_id <= (err_id && !clear_err) || id_ev;
      err_dataflow <= (err_dataflow && !clear_err) || df_ev;
    end
endmodule

// File: doc/pe_result_collector.md
Name: pe_result_collector

Overview:
- Receiver at the bottom edge of a PE column.
- Captures the per-cycle, non-backpressured result bus a PE drives (valid, c, id, last, control, bad_dataflow) into a small FIFO.
- Re-presents the results as a ready/valid stream to the accumulator/scratchpad writer.
- Checks group/id consistency and reports overflow and dataflow errors via sticky flags.

Parameters:
C_W, 20, width of result c
ID_W, 3, width of id
DEPTH, 8, FIFO entries (power of two, >=2)
TCNT_W, 8, width of completed-tile counter

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
in_valid  in  1  PE result valid this cycle (no backpressure)
in_c  in  C_W  PE result
in_id  in  ID_W  PE id
in_last  in  1  last row of current group
in_propagate  in  1  PE control propagate (carried through only)
in_bad_dataflow  in  1  PE bad-dataflow indication
out_valid  out  1  head entry available
out_ready  in  1  consumer accepts head
out_c  out  C_W  head result
out_id  out  ID_W  head id
out_last  out  1  head last flag
out_propagate  out  1  head propagate bit
level  out  log2(DEPTH)+1  current occupancy
tiles_done  out  TCNT_W  count of popped entries with last=1, wraps
err_overflow  out  1  sticky: entry dropped because FIFO full
err_id  out  1  sticky: id changed inside a group
err_dataflow  out  1  sticky: in_bad_dataflow seen with in_valid
clear_err  in  1  synchronous clear of all sticky errors

Behaviour:
- Interface decision: one clock; reset is asynchronous and active-low, ports clk and rst_n.
- On rst_n low, asynchronously: pointers, level, tiles_done and all err_* go to 0; FSM goes to IDLE; out_valid=0.
- out_c/out_id/out_last/out_propagate are don't-care while out_valid=0. The bench checks them only when out_valid=1.
- Push:
  - in_valid=1 writes {c,id,last,propagate} at the write pointer.
  - A push is accepted if level<DEPTH, or if level==DEPTH and a pop happens in the same cycle.
- Pop: out_valid && out_ready advances the read pointer.
- Latency: an entry pushed in cycle N is visible at out_valid no earlier than N+1. There is no combinational bypass when empty.
- Level:
  - push only: +1; pop only: -1; both in the same cycle: unchanged.
  - out_valid = (level!=0).
- Pointers wrap modulo DEPTH.
- Overflow: in_valid while full with no pop -> entry dropped, err_overflow set; FIFO contents unchanged.
- Group FSM:
  - IDLE: on in_valid, latch grp_id=in_id. Stay in IDLE if in_last=1, else go to IN_GROUP.
  - IN_GROUP: on in_valid with in_id!=grp_id, set err_id; the entry is still pushed and grp_id is not updated.
  - IN_GROUP: on in_valid with in_last=1, go to IDLE.
  - The FSM advances on every in_valid, including dropped (overflow) entries.
- err_dataflow: set when in_valid && in_bad_dataflow. The entry is still pushed.
- Sticky errors:
  - clear_err=1 zeros all three at the next edge.
  - If a new error event occurs in the same cycle as clear_err, set wins.
- tiles_done: +1 on each pop whose entry has last=1; wraps from 2^TCNT_W-1 to 0.
- A reset mid-group or mid-burst discards all buffered entries; no partial output follows reset release.
- out_* must hold stable while out_valid=1 and out_ready=0.

Test Plan:
- Single group, out_ready=1: 4 valid cycles, c=1,2,3,4, id=5, last on the 4th.
  -> Outputs c=1..4 in order, each one cycle after its input; out_last only with c=4; tiles_done=1; no errors.
- Fill/overflow, out_ready=0: 9 consecutive valid cycles with c=10..18.
  -> level=8, err_overflow=1. Draining then yields exactly 10..17; c=18 is lost.
- Full plus simultaneous pop: level=8, out_ready=1 and in_valid the same cycle with c=99.
  -> level stays 8, no overflow; 99 emerges after the 7 older entries.
- Id check: group starts id=2, third entry id=3, last on the fourth.
  -> err_id=1 from the cycle after the third input; all 4 entries output with their own ids.
  -> clear_err then a clean group -> err_id=0 and it stays 0.
- Dataflow/clear race: in_valid with in_bad_dataflow=1 in the same cycle as clear_err=1.
  -> err_dataflow=1 afterwards.
  -> A later clear_err with no event -> 0.
- Async reset: with level=5, mid-group, pulse rst_n low between edges.
  -> Immediately out_valid=0, level=0, tiles_done=0, errors=0.
  -> After release, a new group id=1 flows normally with no err_id.
